// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: FSM state encoding and transaction owner.
package mem_arb_pkg;

  // Arbiter FSM: one transaction in flight at most.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  // Which requester owns the transaction currently in flight.
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: instruction fetch and LSU share a single memory
// port. LSU has priority, but fetch is guaranteed a grant after STARVE_MAX
// consecutive LSU grants taken while fetch was waiting.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  // instruction fetch
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  output logic                o_if_gnt,
  output logic                o_if_rvalid,
  output logic [DATA_W-1:0]   o_if_rdata,
  // load/store unit
  input  logic                i_ls_req,
  input  logic [ADDR_W-1:0]   i_ls_addr,
  input  logic                i_ls_wren,
  input  logic [DATA_W/8-1:0] i_ls_bmask,
  input  logic [DATA_W-1:0]   i_ls_wdata,
  output logic                o_ls_gnt,
  output logic                o_ls_rvalid,
  output logic [DATA_W-1:0]   o_ls_rdata,
  // memory port
  output logic                o_mem_req,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic                o_mem_wren,
  output logic [DATA_W/8-1:0] o_mem_bmask,
  output logic [DATA_W-1:0]   o_mem_wdata,
  input  logic                i_mem_gnt,
  input  logic                i_mem_rvalid,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  output logic                o_busy
);

  localparam int BM_W   = DATA_W / 8;
  localparam int STRK_W = $clog2(STARVE_MAX + 1);
  localparam logic [STRK_W-1:0] STRK_MAX = STRK_W'(STARVE_MAX);

  state_e              state_reg, state_next;
  owner_e              owner_reg, owner_next;
  logic [STRK_W-1:0]   streak_reg, streak_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic                wren_reg, wren_next;
  logic [BM_W-1:0]     bmask_reg, bmask_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;

  // LSU wins any contest unless fetch has already been passed over STARVE_MAX times.
  logic ls_wins;
  assign ls_wins = i_ls_req && !(i_if_req && (streak_reg == STRK_MAX));

  // Next-state, capture and handshake logic; reset forces every strobe low.
  always_comb begin
    state_next  = state_reg;
    owner_next  = owner_reg;
    streak_next = streak_reg;
    addr_next   = addr_reg;
    wren_next   = wren_reg;
    bmask_next  = bmask_reg;
    wdata_next  = wdata_reg;
    o_if_gnt    = 1'b0;
    o_ls_gnt    = 1'b0;
    o_if_rvalid = 1'b0;
    o_ls_rvalid = 1'b0;
    o_mem_req   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (ls_wins) begin
          o_ls_gnt   = 1'b1;
          owner_next = OWN_LS;
          addr_next  = i_ls_addr;
          wren_next  = i_ls_wren;
          bmask_next = i_ls_bmask;
          wdata_next = i_ls_wdata;
          state_next = REQ;
          // Streak only counts LSU wins that actually made fetch wait.
          if (i_if_req && (streak_reg != STRK_MAX)) begin
            streak_next = streak_reg + 1'b1;
          end
        end else if (i_if_req) begin
          o_if_gnt    = 1'b1;
          owner_next  = OWN_IF;
          addr_next   = i_if_addr;
          wren_next   = 1'b0;
          bmask_next  = '1;
          wdata_next  = '0;
          streak_next = '0;
          state_next  = REQ;
        end
      end
      REQ: begin
        o_mem_req = 1'b1;
        if (i_mem_gnt) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (i_mem_rvalid) begin
          o_if_rvalid = (owner_reg == OWN_IF);
          o_ls_rvalid = (owner_reg == OWN_LS);
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (i_reset) begin
      o_if_gnt    = 1'b0;
      o_ls_gnt    = 1'b0;
      o_if_rvalid = 1'b0;
      o_ls_rvalid = 1'b0;
      o_mem_req   = 1'b0;
    end
  end

  // State and captured-request registers; reset abandons any transaction in flight.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg  <= IDLE;
      owner_reg  <= OWN_IF;
      streak_reg <= '0;
      addr_reg   <= '0;
      wren_reg   <= 1'b0;
      bmask_reg  <= '0;
      wdata_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      owner_reg  <= owner_next;
      streak_reg <= streak_next;
      addr_reg   <= addr_next;
      wren_reg   <= wren_next;
      bmask_reg  <= bmask_next;
      wdata_reg  <= wdata_next;
    end
  end

  assign o_mem_addr  = addr_reg;
  assign o_mem_wren  = wren_reg;
  assign o_mem_bmask = bmask_reg;
  assign o_mem_wdata = wdata_reg;
  // Only one transaction is ever outstanding, so both requesters can see the raw data.
  assign o_if_rdata  = i_mem_rdata;
  assign o_ls_rdata  = i_mem_rdata;
  assign o_busy      = !i_reset && (state_reg != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios, a transaction-level model checked
// every cycle, and literal expectations on grant order and timing.
module tb_mem_arbiter;

  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req = 1'b0;
  logic [31:0] ls_addr = 32'h0;
  logic        ls_wren = 1'b0;
  logic [3:0]  ls_bmask = 4'h0;
  logic [31:0] ls_wdata = 32'h0;
  logic        ls_gnt, ls_rvalid;
  logic [31:0] ls_rdata;
  logic        mem_req, mem_wren;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_bmask;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        busy;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(if_gnt),
    .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
    .i_ls_req(ls_req), .i_ls_addr(ls_addr), .i_ls_wren(ls_wren),
    .i_ls_bmask(ls_bmask), .i_ls_wdata(ls_wdata), .o_ls_gnt(ls_gnt),
    .o_ls_rvalid(ls_rvalid), .o_ls_rdata(ls_rdata),
    .o_mem_req(mem_req), .o_mem_addr(mem_addr), .o_mem_wren(mem_wren),
    .o_mem_bmask(mem_bmask), .o_mem_wdata(mem_wdata),
    .i_mem_gnt(mem_gnt), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
    .o_busy(busy)
  );

  typedef struct { logic [31:0] addr; bit wren; logic [3:0] bmask; logic [31:0] wdata; } req_t;
  typedef struct { int cyc; bit ls; } gev_t;
  typedef struct { int cyc; bit ls; logic [31:0] data; } rev_t;
  typedef struct { int cyc; logic [31:0] addr; bit wren; logic [3:0] bmask; logic [31:0] wdata; } mev_t;

  // Bench memory contents: fixed pattern, with the instruction at 0x100 pinned.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0000_0013 : (a ^ 32'hC0DE_0000);
  endfunction

  // ---------------- compare process state (written only by the negedge block)
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   if_gnt_s = 0, ls_gnt_s = 0, mem_acc_s = 0, busy_s = 0;
  gev_t glog[$];
  rev_t rlog[$];
  mev_t mlog[$];
  // model: one transaction record plus a count of fetch-starving LSU wins
  bit          m_active = 0, m_issued = 0, m_ls = 0;
  logic [31:0] m_addr = 0, m_wdata = 0;
  bit          m_wren = 0;
  logic [3:0]  m_bmask = 0;
  int          m_streak = 0;

  // ---------------- stimulus state (written only by the initial block)
  req_t if_q[$];
  req_t ls_q[$];
  int   stall_cfg = 0, wait_cnt = 0, n_timeouts = 0;
  bit   rst_arm = 0, rst_phase = 0, done = 0;
  int   sc_start [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_s(input string name, input string act, input string exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%s expected=%s", name, act, exp);
    end
  endtask

  function automatic string trace(input int lo, input int hi);
    string s = "";
    foreach (glog[i]) if (glog[i].cyc >= lo && glog[i].cyc < hi) s = {s, glog[i].ls ? "L" : "I"};
    return s;
  endfunction

  function automatic int fg(input int lo, input int hi, input bit ls);
    foreach (glog[i]) if (glog[i].cyc >= lo && glog[i].cyc < hi && glog[i].ls == ls) return glog[i].cyc;
    return -1;
  endfunction

  function automatic rev_t fr(input int lo, input int hi, input bit ls);
    rev_t r = '{-1, 1'b0, 32'h0};
    foreach (rlog[i]) if (rlog[i].cyc >= lo && rlog[i].cyc < hi && rlog[i].ls == ls) return rlog[i];
    return r;
  endfunction

  function automatic mev_t fm(input int lo, input int hi);
    mev_t m = '{-1, 32'h0, 1'b0, 4'h0, 32'h0};
    foreach (mlog[i]) if (mlog[i].cyc >= lo && mlog[i].cyc < hi) return mlog[i];
    return m;
  endfunction

  task automatic lit_checks();
    int   g, n_all, n_same, n_rv;
    mev_t m;
    rev_t r;
    // S1: lone fetch, memory grants at once
    g = fg(sc_start[0], sc_start[1], 1'b0);
    m = fm(sc_start[0], sc_start[1]);
    r = fr(sc_start[0], sc_start[1], 1'b0);
    chk_s("s1_trace", trace(sc_start[0], sc_start[1]), "I");
    chk("s1_memreq_cyc", 32'(m.cyc), 32'(g + 1));
    chk("s1_mem_addr", m.addr, 32'h100);
    chk("s1_mem_bmask", 32'(m.bmask), 32'hF);
    chk("s1_rv_cyc", 32'(r.cyc), 32'(g + 2));
    chk("s1_rdata", r.data, 32'h0000_0013);
    // S2: fetch and LSU store together
    m = fm(sc_start[1], sc_start[2]);
    chk_s("s2_trace", trace(sc_start[1], sc_start[2]), "LI");
    chk("s2_mem_wren", 32'(m.wren), 32'h1);
    chk("s2_mem_addr", m.addr, 32'h2000);
    chk("s2_mem_wdata", m.wdata, 32'hDEAD_BEEF);
    chk("s2_if_after_ls", 32'(fg(sc_start[1], sc_start[2], 1'b0)),
        32'(fr(sc_start[1], sc_start[2], 1'b1).cyc + 1));
    // S3: starvation limit
    chk_s("s3_trace", trace(sc_start[2], sc_start[3]), "LLLLILLI");
    // S4: memory stalls five cycles
    g = fg(sc_start[3], sc_start[4], 1'b0);
    n_all = 0;
    n_same = 0;
    foreach (mlog[i]) if (mlog[i].cyc >= sc_start[3] && mlog[i].cyc < g) begin
      n_all++;
      if (mlog[i].addr == 32'h3000 && !mlog[i].wren && mlog[i].bmask == 4'hF) n_same++;
    end
    chk_s("s4_trace", trace(sc_start[3], sc_start[4]), "LI");
    chk("s4_memreq_cycles", 32'(n_all), 32'd6);
    chk("s4_memreq_stable", 32'(n_same), 32'd6);
    chk("s4_if_after_ls", 32'(g), 32'(fr(sc_start[3], sc_start[4], 1'b1).cyc + 1));
    // S5: reset in RESP then a stray response
    n_rv = 0;
    foreach (rlog[i]) if (rlog[i].cyc >= sc_start[4] && rlog[i].cyc < sc_start[5]) n_rv++;
    chk_s("s5_trace", trace(sc_start[4], sc_start[5]), "LLLLLI");
    chk("s5_rv_count", 32'(n_rv), 32'd5);
    chk("timeouts", 32'(n_timeouts), 32'd0);
  endtask

  // Compare process: model predicts every output each cycle, then advances.
  always @(negedge clk) begin
    bit lw, e_ig, e_lg, e_mr, e_b, e_ir, e_lr;
    cyc++;
    lw = 0; e_ig = 0; e_lg = 0; e_mr = 0; e_b = 0; e_ir = 0; e_lr = 0;
    if (rst) begin
      // everything quiet while reset is held
    end else if (!m_active) begin
      lw   = ls_req && !(if_req && m_streak == STARVE);
      e_lg = lw;
      e_ig = if_req && !lw;
    end else if (!m_issued) begin
      e_b  = 1;
      e_mr = 1;
    end else begin
      e_b  = 1;
      e_ir = mem_rvalid && !m_ls;
      e_lr = mem_rvalid && m_ls;
    end
    chk("if_gnt", 32'(if_gnt), 32'(e_ig));
    chk("ls_gnt", 32'(ls_gnt), 32'(e_lg));
    chk("mem_req", 32'(mem_req), 32'(e_mr));
    chk("busy", 32'(busy), 32'(e_b));
    chk("if_rvalid", 32'(if_rvalid), 32'(e_ir));
    chk("ls_rvalid", 32'(ls_rvalid), 32'(e_lr));
    if (e_mr) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wren", 32'(mem_wren), 32'(m_wren));
      chk("mem_bmask", 32'(mem_bmask), 32'(m_bmask));
      if (m_wren) chk("mem_wdata", mem_wdata, m_wdata);
    end
    if (e_ir) chk("if_rdata", if_rdata, mem_fn(m_addr));
    if (e_lr) chk("ls_rdata", ls_rdata, mem_fn(m_addr));

    if (if_gnt) glog.push_back('{cyc, 1'b0});
    if (ls_gnt) glog.push_back('{cyc, 1'b1});
    if (mem_req) mlog.push_back('{cyc, mem_addr, mem_wren, mem_bmask, mem_wdata});
    if (if_rvalid) rlog.push_back('{cyc, 1'b0, if_rdata});
    if (ls_rvalid) rlog.push_back('{cyc, 1'b1, ls_rdata});
    if_gnt_s  = if_gnt;
    ls_gnt_s  = ls_gnt;
    mem_acc_s = mem_req && mem_gnt;
    busy_s    = busy;

    if (rst) begin
      m_active = 0; m_issued = 0; m_streak = 0;
    end else if (!m_active) begin
      if (e_lg) begin
        m_active = 1; m_issued = 0; m_ls = 1;
        m_addr = ls_addr; m_wren = ls_wren; m_bmask = ls_bmask; m_wdata = ls_wdata;
        if (if_req && m_streak < STARVE) m_streak++;
      end else if (e_ig) begin
        m_active = 1; m_issued = 0; m_ls = 0;
        m_addr = if_addr; m_wren = 0; m_bmask = 4'hF; m_wdata = 32'h0;
        m_streak = 0;
      end
    end else if (!m_issued) begin
      if (mem_gnt) m_issued = 1;
    end else if (mem_rvalid) begin
      m_active = 0;
    end

    if (done) begin
      lit_checks();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  // One cycle of requesters + memory: drive just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (if_gnt_s && if_q.size() > 0) void'(if_q.pop_front());
    if (ls_gnt_s && ls_q.size() > 0) void'(ls_q.pop_front());
    if_req = (if_q.size() > 0);
    if_addr = 32'h0;
    if (if_req) if_addr = if_q[0].addr;
    ls_req = (ls_q.size() > 0);
    ls_addr = 32'h0; ls_wren = 1'b0; ls_bmask = 4'h0; ls_wdata = 32'h0;
    if (ls_req) begin
      ls_addr = ls_q[0].addr; ls_wren = ls_q[0].wren;
      ls_bmask = ls_q[0].bmask; ls_wdata = ls_q[0].wdata;
    end
    mem_rvalid = mem_acc_s;
    mem_rdata  = mem_acc_s ? mem_fn(mem_addr) : 32'h0;
    if (rst_phase) begin
      rst = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata = 32'hBAD0_BAD0;
      rst_phase = 0;
    end else if (rst_arm && mem_acc_s) begin
      rst = 1'b1;
      rst_arm = 0;
      rst_phase = 1;
    end
    #1;
    if (mem_acc_s || !mem_req) wait_cnt = 0;
    mem_gnt = 1'b0;
    if (mem_req) begin
      if (wait_cnt >= stall_cfg) mem_gnt = 1'b1;
      else wait_cnt++;
    end
  endtask

  task automatic run(input int budget);
    int n = 0;
    bit idle = 0;
    while (!idle && n < budget) begin
      tick();
      n++;
      idle = (if_q.size() == 0) && (ls_q.size() == 0) && !busy_s && !mem_acc_s &&
             !if_gnt_s && !ls_gnt_s && !rst_phase;
    end
    if (!idle) n_timeouts++;
    tick();
    tick();
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    tick();

    sc_start[0] = cyc;
    if_q.push_back('{32'h100, 1'b0, 4'hF, 32'h0});
    run(50);

    sc_start[1] = cyc;
    if_q.push_back('{32'h104, 1'b0, 4'hF, 32'h0});
    ls_q.push_back('{32'h2000, 1'b1, 4'hF, 32'hDEAD_BEEF});
    run(50);

    sc_start[2] = cyc;
    if_q.push_back('{32'h200, 1'b0, 4'hF, 32'h0});
    if_q.push_back('{32'h204, 1'b0, 4'hF, 32'h0});
    for (int i = 0; i < 6; i++) ls_q.push_back('{32'h400 + 32'(4 * i), 1'b0, 4'hF, 32'h0});
    run(200);

    sc_start[3] = cyc;
    stall_cfg = 5;
    ls_q.push_back('{32'h3000, 1'b0, 4'hF, 32'h0});
    if_q.push_back('{32'h208, 1'b0, 4'hF, 32'h0});
    run(100);
    stall_cfg = 0;

    sc_start[4] = cyc;
    if_q.push_back('{32'h500, 1'b0, 4'hF, 32'h0});
    for (int i = 0; i < 5; i++) ls_q.push_back('{32'h600 + 32'(4 * i), 1'b0, 4'hF, 32'h0});
    rst_arm = 1;
    run(200);

    sc_start[5] = cyc + 1;
    done = 1;
    repeat (5) @(posedge clk);
    $display("FAIL finish_not_reached actual=0 expected=1");
    $fatal(1, "compare process did not finish");
  end

endmodule
